// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
//   bcd_t    : one 4-bit digit (0-9 decimal, 10-15 shown as hex)
//   seg_t    : segment vector {g,f,e,d,c,b,a}, active-high inside the design
//   SEG_OFF  : all segments dark (active-high)
//   SEG_LUT  : active-high segment patterns for 0-9, A, b, C, d, E, F
//   frame_t  : one captured set of digits plus its leading-zero blank flag
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t SEG_LUT [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  typedef struct packed {
    bcd_t [NUM_DIGITS-1:0] digits;
    logic                  blank_lz;
  } frame_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-to-segment decoder, active-high output.
//   digit : digit value to show
//   blank : force all segments dark
//   seg_c : active-high segment pattern {g,f,e,d,c,b,a}
module seg_decoder
  import sevenseg_pkg::*;
(
  input  bcd_t digit,
  input  logic blank,
  output seg_t seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    if (!blank) begin
      seg_c = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit 7-segment display.
// One digit is lit per scan slot; each slot opens with a guard interval with every
// anode off to avoid ghosting. New digits are taken only at the end of a full frame,
// so a frame never mixes old and new values.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   digit0_i..digit3_i    : ones..thousands digits
//   load_i, blank_lz_i    : capture digits and blank flag into the pending register
//   seg_o                 : registered segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   an_o                  : registered anode enables (an_o[k] = digit k), polarity per AN_ACT_LOW
//   frame_o               : one-cycle pulse when the display register has just been refreshed
module seven_seg_scanner
  import sevenseg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          AN_ACT_LOW   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  bcd_t       digit0_i,
  input  bcd_t       digit1_i,
  input  bcd_t       digit2_i,
  input  bcd_t       digit3_i,
  input  logic       load_i,
  input  logic       blank_lz_i,
  output seg_t       seg_o,
  output logic [3:0] an_o,
  output logic       frame_o
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SLOT_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

  // Reset values are "everything dark" expressed in the output polarity.
  localparam seg_t       SEG_RST = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [3:0] AN_RST  = AN_ACT_LOW ? 4'hF : 4'h0;

  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  frame_t            pending_q, pending_d;
  frame_t            display_q, display_d;
  logic              frame_d;
  seg_t              seg_d;
  logic [3:0]        an_d;

  logic              wrap;
  logic [3:0]        blank;
  logic [3:0]        an_hi;
  bcd_t              sel_digit;
  seg_t              dec_seg;

  // Divider, slot counter and pending/display register next-state.
  always_comb begin
    wrap      = (div_cnt_q == CNT_MAX);
    div_cnt_d = div_cnt_q + CNT_W'(1);
    slot_d    = slot_q;
    pending_d = pending_q;
    display_d = display_q;
    frame_d   = 1'b0;

    if (load_i) begin
      pending_d.digits   = {digit3_i, digit2_i, digit1_i, digit0_i};
      pending_d.blank_lz = blank_lz_i;
    end

    if (wrap) begin
      div_cnt_d = '0;
      slot_d    = slot_q + SLOT_W'(1);
      // Frame boundary: take the pending value as it stood before any load this cycle.
      if (slot_q == SLOT_W'(3)) begin
        display_d = pending_q;
        frame_d   = 1'b1;
      end
    end
  end

  // Leading-zero blanking chain; the ones digit is always shown.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = display_q.blank_lz && (display_q.digits[3] == 4'd0);
    blank[2] = blank[3] && (display_q.digits[2] == 4'd0);
    blank[1] = blank[2] && (display_q.digits[1] == 4'd0);
  end

  assign sel_digit = display_q.digits[slot_q];

  seg_decoder u_seg_decoder (
    .digit (sel_digit),
    .blank (blank[slot_q]),
    .seg_c (dec_seg)
  );

  // Anode selection with guard interval, then output polarity.
  always_comb begin
    an_hi = 4'b0000;
    if (div_cnt_q >= GUARD_END) begin
      an_hi[slot_q] = 1'b1;
    end
    an_d  = AN_ACT_LOW ? ~an_hi : an_hi;
    seg_d = SEG_ACT_LOW ? ~dec_seg : dec_seg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      slot_q    <= '0;
      pending_q <= '0;
      display_q <= '0;
      frame_o   <= 1'b0;
      an_o      <= AN_RST;
      seg_o     <= SEG_RST;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      display_q <= display_d;
      frame_o   <= frame_d;
      an_o      <= an_d;
      seg_o     <= seg_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with SCAN_DIV=8, GUARD_CYCLES=2.
// dut uses active-low segments and anodes; dut_hi shares all inputs but is active-high.
module tb_seven_seg_scanner;
  import sevenseg_pkg::*;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned GUARD    = 2;
  localparam int          FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  bcd_t       d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  seg_t       seg, seg_hi;
  logic [3:0] an, an_hi;
  logic       frame, frame_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .SCAN_DIV(SCAN_DIV), .GUARD_CYCLES(GUARD), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .digit0_i(d0), .digit1_i(d1), .digit2_i(d2), .digit3_i(d3),
    .load_i(load), .blank_lz_i(blank_lz),
    .seg_o(seg), .an_o(an), .frame_o(frame)
  );

  seven_seg_scanner #(
    .SCAN_DIV(SCAN_DIV), .GUARD_CYCLES(GUARD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) dut_hi (
    .clk_i(clk), .rst_ni(rst_ni),
    .digit0_i(d0), .digit1_i(d1), .digit2_i(d2), .digit3_i(d3),
    .load_i(load), .blank_lz_i(blank_lz),
    .seg_o(seg_hi), .an_o(an_hi), .frame_o(frame_hi)
  );

  // One load with its expected active-low segments per digit (exp[k] = digit k).
  typedef struct packed {
    bcd_t             d3, d2, d1, d0;
    logic             bl;
    logic [3:0][6:0]  exp;
  } vec_t;

  function automatic vec_t mk(input bcd_t a3, input bcd_t a2, input bcd_t a1, input bcd_t a0,
                              input logic bl, input seg_t e3, input seg_t e2,
                              input seg_t e1, input seg_t e0);
    vec_t r;
    r.d3 = a3; r.d2 = a2; r.d1 = a1; r.d0 = a0;
    r.bl = bl;
    r.exp = {e3, e2, e1, e0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns one negedge later with load deasserted.
  task automatic drive_load(input bcd_t a3, input bcd_t a2, input bcd_t a1, input bcd_t a0,
                            input logic bl);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
    blank_lz = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge where frame_o is high (first cycle of a new frame).
  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < FRAME + 8 && !ok; i++) begin
      @(negedge clk);
      if (frame) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: frame_o not seen within %0d cycles, required a pulse", FRAME + 8);
    end
  endtask

  // Sample each slot mid-way (cycle 8k+4 counted from the frame_o cycle).
  task automatic check_frame(input vec_t v, input string name, input int start);
    int cyc;
    logic [3:0] ea;
    cyc = start;
    for (int k = 0; k < 4; k++) begin
      while (cyc < int'(SCAN_DIV) * k + 4) begin
        @(negedge clk);
        cyc++;
      end
      ea = 4'hF & ~(4'b0001 << k);
      chk($sformatf("%s an slot%0d", name, k), 32'(an), 32'(ea));
      chk($sformatf("%s seg slot%0d", name, k), 32'(seg), 32'(v.exp[k]));
      chk($sformatf("%s seg_hi slot%0d", name, k), 32'(seg_hi), 32'(~v.exp[k] & 7'h7F));
      chk($sformatf("%s an_hi slot%0d", name, k), 32'(an_hi), 32'(~ea & 4'hF));
    end
  endtask

  // Called at the negedge where rst_ni is released; checks one full frame of scanning
  // with a cleared display (all digits '0').
  task automatic scan_check(input string name);
    int div, slot;
    logic [3:0] ea;
    for (int n = 1; n <= FRAME; n++) begin
      @(negedge clk);
      div  = (n - 1) % int'(SCAN_DIV);
      slot = (n - 1) / int'(SCAN_DIV);
      ea   = (div >= int'(GUARD)) ? (4'hF & ~(4'b0001 << slot)) : 4'hF;
      chk($sformatf("%s an n=%0d", name, n), 32'(an), 32'(ea));
      chk($sformatf("%s seg n=%0d", name, n), 32'(seg), 32'(7'h40));
      chk($sformatf("%s frame n=%0d", name, n), 32'(frame), 32'(n == FRAME));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    vec_t v9, v2, ve;

    vecs[0] = mk(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19);
    vecs[1] = mk(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    vecs[2] = mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    vecs[3] = mk(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 7'h7F, 7'h7F, 7'h12, 7'h40);
    vecs[4] = mk(4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 7'h40, 7'h79, 7'h40, 7'h40);
    vecs[5] = mk(4'd0, 4'd8, 4'd0, 4'd9, 1'b1, 7'h7F, 7'h00, 7'h40, 7'h10);
    vecs[6] = mk(4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 7'h08, 7'h03, 7'h46, 7'h21);
    vecs[7] = mk(4'hF, 4'hE, 4'd6, 4'd5, 1'b1, 7'h0E, 7'h06, 7'h02, 7'h12);
    v9 = mk(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 7'h10, 7'h10, 7'h10, 7'h10);
    v2 = mk(4'd2, 4'd2, 4'd2, 4'd2, 1'b0, 7'h24, 7'h24, 7'h24, 7'h24);
    ve = mk(4'd0, 4'd0, 4'd0, 4'hE, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h06);

    // Reset values and first frame of scanning.
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset an", 32'(an), 32'(4'hF));
    chk("reset seg", 32'(seg), 32'(7'h7F));
    chk("reset frame", 32'(frame), 32'(1'b0));
    chk("reset seg_hi", 32'(seg_hi), 32'(7'h00));
    chk("reset an_hi", 32'(an_hi), 32'(4'h0));
    chk("reset frame_hi", 32'(frame_hi), 32'(1'b0));
    rst_ni = 1'b1;
    scan_check("scan0");

    // Table of loads, each displayed after the next frame boundary.
    for (int i = 0; i < 8; i++) begin
      drive_load(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].bl);
      wait_frame();
      @(negedge clk);
      chk($sformatf("vec%0d frame width", i), 32'(frame), 32'(1'b0));
      check_frame(vecs[i], $sformatf("vec%0d", i), 1);
    end

    // Two loads in one frame: the old display stays until the wrap, the last load wins.
    drive_load(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    drive_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    @(negedge clk);
    chk("preload old digit3", 32'(seg), 32'(7'h0E));
    wait_frame();
    @(negedge clk);
    check_frame(v9, "lastwins", 1);

    // Load on the wrap cycle itself: old pending shown for one more frame.
    repeat (3) @(negedge clk);
    drive_load(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
    chk("wrap frame pulse", 32'(frame), 32'(1'b1));
    check_frame(v9, "coinc old", 0);
    wait_frame();
    @(negedge clk);
    check_frame(v2, "coinc new", 1);

    // Hex E with blanking, both polarities.
    drive_load(4'd0, 4'd0, 4'd0, 4'hE, 1'b1);
    wait_frame();
    check_frame(ve, "hexE", 0);

    // Asynchronous reset mid-slot, then restart with a cleared display.
    wait_frame();
    repeat (4) @(negedge clk);
    chk("pre-reset an", 32'(an), 32'(4'hE));
    chk("pre-reset seg", 32'(seg), 32'(7'h06));
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("async an", 32'(an), 32'(4'hF));
    chk("async seg", 32'(seg), 32'(7'h7F));
    chk("async frame", 32'(frame), 32'(1'b0));
    chk("async seg_hi", 32'(seg_hi), 32'(7'h00));
    chk("async an_hi", 32'(an_hi), 32'(4'h0));
    @(negedge clk);
    rst_ni = 1'b1;
    scan_check("scan1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
